// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 3-digit 7-segment display.
// Digits are loaded into a pending register and only reach the display
// register at a frame boundary, so a frame never mixes old and new digits.
// Each slot starts with a short dead time (all anodes off) to avoid ghosting.
module display_scan_ctrl #(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned BLANK_CYCLES   = 1,
    parameter bit          LZ_BLANK       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic [3:0] u,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done,
    output logic       commit
);

    localparam int unsigned      CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]       AN_OFF  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {StIdle, StC, StD, StU} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick;
    logic             boundary;

    // {hundreds, tens, units}
    logic [11:0]      pend_q, disp_q;
    logic             pend_flag_q;

    logic [6:0]       seg_d;
    logic [2:0]       an_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40; // invalid BCD shows a dash
        endcase
    endfunction

    assign tick     = (state_q != StIdle) && (count_q == CNT_MAX);
    assign boundary = enable && tick && (state_q == StU);

    // State register and slot prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state: slot sequencing, prescaler restarts on every slot change
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!enable) begin
            state_d = StIdle;
            count_d = '0;
        end else if (state_q == StIdle) begin
            state_d = StC;
            count_d = '0;
        end else begin
            count_d = tick ? '0 : count_q + CNT_W'(1);
            if (tick) begin
                case (state_q)
                    StC:     state_d = StD;
                    StD:     state_d = StU;
                    default: state_d = StC;
                endcase
            end
        end
    end

    // Pending/display registers; a load in the boundary cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            disp_q      <= '0;
            pend_flag_q <= 1'b0;
            frame_done  <= 1'b0;
            commit      <= 1'b0;
        end else begin
            frame_done <= boundary;
            commit     <= boundary && pend_flag_q;
            if (boundary && pend_flag_q) begin
                disp_q <= pend_q;
            end
            if (load) begin
                pend_q      <= {c, d, u};
                pend_flag_q <= 1'b1;
            end else if (boundary) begin
                pend_flag_q <= 1'b0;
            end
        end
    end

    // Output decode: current slot digit with leading-zero blanking and dead time
    always_comb begin
        logic [3:0] dig;
        logic       blank;
        logic [2:0] sel;
        logic [6:0] seg_raw;
        logic [2:0] an_raw;
        dig   = 4'd0;
        blank = 1'b1;
        sel   = 3'b000;
        case (state_q)
            StC: begin
                dig   = disp_q[11:8];
                blank = LZ_BLANK && (dig == 4'd0);
                sel   = 3'b100;
            end
            StD: begin
                dig   = disp_q[7:4];
                blank = LZ_BLANK && (disp_q[11:8] == 4'd0) && (dig == 4'd0);
                sel   = 3'b010;
            end
            StU: begin
                dig   = disp_q[3:0];
                blank = 1'b0;
                sel   = 3'b001;
            end
            default: ;
        endcase
        seg_raw = blank ? 7'h00 : seg_decode(dig);
        an_raw  = (32'(count_q) >= BLANK_CYCLES) ? sel : 3'b000;
        // Going dark is immediate once enable is sampled low
        if (!enable || state_q == StIdle) begin
            seg_raw = 7'h00;
            an_raw  = 3'b000;
        end
        seg_d = seg_raw ^ {7{SEG_ACTIVE_LOW}};
        an_d  = an_raw ^ {3{AN_ACTIVE_LOW}};
    end

    // Registered segment and anode drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a frame-level model (cycles since scan start ->
// slot and position) predicts every output cycle; directed scenarios pin
// literal segment values, then a randomized run stresses load/enable timing.
module tb_display_scan_ctrl;

    localparam int T = 4;
    localparam int B = 1;

    logic       clk = 1'b0;
    logic       rst_n, enable, load;
    logic [3:0] c, d, u;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done, commit;

    int errors = 0;
    int checks = 0;
    int n_commit = 0;
    int n_fd = 0;

    display_scan_ctrl #(
        .TICK_DIV      (T),
        .BLANK_CYCLES  (B),
        .LZ_BLANK      (1'b1),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .c         (c),
        .d         (d),
        .u         (u),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done),
        .commit    (commit)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [3:0] m_disp [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] m_pend [3] = '{4'd0, 4'd0, 4'd0};
    bit         m_pflag = 0;
    bit         m_active = 0;
    int         m_run = 0;
    logic [6:0] exp_seg = 7'h7F;
    logic [2:0] exp_an = 3'b111;
    logic       exp_fd = 1'b0;
    logic       exp_cm = 1'b0;

    int         slot, pos;
    bit         bnd;
    logic [3:0] dig;
    logic [6:0] s;
    logic [2:0] a;

    always @(negedge rst_n) begin
        m_disp = '{4'd0, 4'd0, 4'd0};
        m_pend = '{4'd0, 4'd0, 4'd0};
        m_pflag = 0; m_active = 0; m_run = 0;
        exp_seg = 7'h7F; exp_an = 3'b111; exp_fd = 1'b0; exp_cm = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bnd = 0; s = 7'h00; a = 3'b000;
            if (enable && m_active) begin
                slot = (m_run / T) % 3;
                pos  = m_run % T;
                dig  = m_disp[slot];
                if (slot == 0 && dig == 0) s = 7'h00;
                else if (slot == 1 && m_disp[0] == 0 && dig == 0) s = 7'h00;
                else s = seg_tbl[dig];
                if (pos >= B) a = 3'b100 >> slot;
                bnd = (slot == 2) && (pos == T - 1);
            end
            exp_seg = ~s;
            exp_an  = ~a;
            exp_fd  = bnd;
            exp_cm  = bnd && m_pflag;
            if (bnd && m_pflag) begin
                m_disp  = m_pend;
                m_pflag = 0;
            end
            if (load) begin
                m_pend  = '{c, d, u};
                m_pflag = 1;
            end
            if (!enable) begin
                m_active = 0; m_run = 0;
            end else if (!m_active) begin
                m_active = 1; m_run = 0;
            end else begin
                m_run++;
            end
        end
    end

    // Every-cycle compare, away from the active edge
    always @(negedge clk) begin
        checks++;
        if ({seg, an, frame_done, commit} !== {exp_seg, exp_an, exp_fd, exp_cm}) begin
            errors++;
            $display("FAIL cycle t=%0t: seg/an/fd/cm got %h/%b/%b/%b want %h/%b/%b/%b",
                     $time, seg, an, frame_done, commit, exp_seg, exp_an, exp_fd, exp_cm);
        end
        if (commit === 1'b1) n_commit++;
        if (frame_done === 1'b1) n_fd++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] ci, input logic [3:0] di, input logic [3:0] ui);
        @(posedge clk); #2;
        load = 1'b1; c = ci; d = di; u = ui;
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    task automatic wait_commit(input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (commit === 1'b1) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Wait for an anode pattern, then pin the segment value shown with it
    task automatic show(input logic [2:0] pat, input logic [6:0] want, input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (an === pat) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: anode pattern got %b want %b", name, an, pat);
        end
        chk(name, 32'(seg), 32'(want));
    endtask

    // ---------------- stimulus ----------------
    int base, k, n;
    bit seen;

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; c = 4'd0; d = 4'd0; u = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'h7);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_commit", 32'(commit), 32'h0);

        @(posedge clk); #2;
        rst_n = 1'b1; enable = 1'b1;

        do_load(4'd1, 4'd2, 4'd7);
        wait_commit("commit_127");
        show(3'b011, 7'h79, "h_1");
        show(3'b101, 7'h24, "t_2");
        show(3'b110, 7'h78, "u_7");

        do_load(4'd0, 4'd0, 4'd5);
        wait_commit("commit_005");
        show(3'b011, 7'h7F, "lz_h");
        show(3'b101, 7'h7F, "lz_t");
        show(3'b110, 7'h12, "u_5");

        do_load(4'd0, 4'd0, 4'd0);
        wait_commit("commit_000");
        show(3'b011, 7'h7F, "zero_h");
        show(3'b101, 7'h7F, "zero_t");
        show(3'b110, 7'h40, "zero_u");

        do_load(4'd1, 4'd12, 4'd3);
        wait_commit("commit_1c3");
        show(3'b011, 7'h79, "bad_h");
        show(3'b101, 7'h3F, "bad_t_dash");
        show(3'b110, 7'h30, "bad_u");

        // Two mid-frame loads plus one in the boundary cycle
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1;
        end
        chk("fd_seen", 32'(seen), 32'd1);
        #1 base = n_commit;
        for (k = 1; k <= 12; k++) begin
            @(posedge clk); #2;
            load = (k == 3) || (k == 6) || (k == 11);
            if (k == 3)  begin c = 4'd4; d = 4'd4; u = 4'd4; end
            if (k == 6)  begin c = 4'd8; d = 4'd8; u = 4'd8; end
            if (k == 11) begin c = 4'd3; d = 4'd4; u = 4'd5; end
        end
        load = 1'b0;
        repeat (13) @(posedge clk);
        #1 chk("two_commits", 32'(n_commit - base), 32'd2);
        show(3'b011, 7'h30, "third_h");
        show(3'b110, 7'h12, "third_u");

        // Drop enable while the tens digit is lit
        show(3'b101, 7'h19, "pre_drop_t");
        @(posedge clk); #2;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_an_off", 32'(an), 32'h7);
        base = n_fd;
        repeat (20) @(posedge clk);
        #1 chk("no_fd_idle", 32'(n_fd - base), 32'd0);
        @(posedge clk); #2;
        enable = 1'b1;
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (an !== 3'b111) seen = 1;
        end
        chk("reen_latency", 32'(n), 32'd4);
        chk("reen_first_h", 32'(an), 32'b011);

        // Asynchronous reset mid-slot
        show(3'b110, 7'h12, "pre_rst_u");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_an", 32'(an), 32'h7);
        @(posedge clk); #2;
        rst_n = 1'b1;
        show(3'b011, 7'h7F, "post_rst_h");
        show(3'b110, 7'h40, "post_rst_u0");

        // Randomized load/enable traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            load   = ($urandom_range(3) == 0);
            c      = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
            d      = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
            u      = 4'($urandom_range(15));
            enable = ($urandom_range(39) != 0);
        end
        @(posedge clk); #2;
        load = 1'b0; enable = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
